// File: rtl/alu_result_checker_pkg.sv
// Shared definitions for the ALU result checker: opcodes, error flag
// positions, checker FSM states and small arithmetic helpers.
package alu_result_checker_pkg;

   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_SUB    = 2'b01;
   localparam logic [1:0] OP_AND    = 2'b10;
   localparam logic [1:0] OP_POPCNT = 2'b11;

   localparam int ERR_UNEXPECTED = 0;
   localparam int ERR_OVERFLOW   = 1;
   localparam int ERR_TIMEOUT    = 2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

   // One step of the right-shifting Fibonacci LFSR x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] lfsr_step(input logic [15:0] state);
      logic feedback;
      feedback = state[0] ^ state[2] ^ state[3] ^ state[5];
      return {feedback, state[15:1]};
   endfunction

endpackage

// File: rtl/alu_result_checker_fifo.sv
// Generic single-clock FIFO. A push while full is accepted only when a pop
// frees the slot in the same cycle; a pop while empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_checker.sv
// Consumer end of the ALU result stream. Snoops accepted requests, queues
// the reference result, compares every accepted ALU result against the
// queue head, throttles ready with an LFSR and produces a final verdict.
module alu_result_checker
   import alu_result_checker_pkg::*;
#(
   parameter int          DATA_WIDTH = 8,
   parameter int          OUT_WIDTH  = DATA_WIDTH + 3,
   parameter int          DEPTH      = 8,
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter int          TIMEOUT    = 64
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_req_VALID,
   input  logic                  i_req_READY,
   input  logic [DATA_WIDTH-1:0] i_req_arg0,
   input  logic [DATA_WIDTH-1:0] i_req_arg1,
   input  logic [1:0]            i_req_oper,
   input  logic                  i_res_VALID,
   output logic                  o_res_READY,
   input  logic [OUT_WIDTH-1:0]  i_res_Y,
   input  logic                  i_BP_EN,
   input  logic                  i_END,
   output logic                  o_MISMATCH,
   output logic [15:0]           o_PASS_CNT,
   output logic [15:0]           o_FAIL_CNT,
   output logic [2:0]            o_ERR,
   output logic                  o_DONE,
   output logic                  o_PASS
);

   localparam int TW = $clog2(TIMEOUT + 1);

   // Reference model of the ALU. SUB keeps the full DATA_WIDTH+1 bit
   // difference so large negative results keep their true sign.
   function automatic logic [OUT_WIDTH-1:0] ref_result(
      input logic [1:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [DATA_WIDTH:0]  diff;
      logic [OUT_WIDTH-1:0] ones;
      ref_result = '0;
      case (op)
         OP_ADD: ref_result = OUT_WIDTH'(a) + OUT_WIDTH'(b);
         OP_SUB: begin
            diff       = {1'b0, a} - {1'b0, b};
            ref_result = {{(OUT_WIDTH-DATA_WIDTH-1){diff[DATA_WIDTH]}}, diff};
         end
         OP_AND: ref_result = OUT_WIDTH'(a & b);
         default: begin
            ones = '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
               ones = ones + OUT_WIDTH'(a[i]);
            end
            ref_result = ones;
         end
      endcase
   endfunction

   state_t                 state;
   state_t                 state_next;
   logic [TW-1:0]          tmo_cnt;
   logic [TW-1:0]          tmo_next;
   logic                   timeout_hit;
   logic [15:0]            lfsr;
   logic                   ready_q;
   logic [15:0]            pass_cnt;
   logic [15:0]            fail_cnt;
   logic [2:0]             err;
   logic                   mismatch;

   logic                   req_fire;
   logic                   res_accept;
   logic                   pop_ok;
   logic                   unexpected;
   logic                   overflow;
   logic                   match;
   logic [OUT_WIDTH-1:0]   expected;
   logic [OUT_WIDTH-1:0]   head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;

   assign req_fire   = i_req_VALID && i_req_READY;
   assign res_accept = i_res_VALID && o_res_READY;
   assign pop_ok     = res_accept && !fifo_empty;
   assign unexpected = res_accept && fifo_empty;
   assign overflow   = req_fire && fifo_full && !pop_ok;
   assign match      = (head == i_res_Y);
   assign expected   = ref_result(i_req_oper, i_req_arg0, i_req_arg1);

   sync_fifo #(
      .WIDTH(OUT_WIDTH),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (i_CLK),
      .rst  (i_RST),
      .push (req_fire),
      .pop  (res_accept),
      .din  (expected),
      .dout (head),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   // Backpressure source: the LFSR free-runs and its low bit is registered.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         lfsr    <= SEED;
         ready_q <= 1'b1;
      end else begin
         lfsr    <= lfsr_step(lfsr);
         ready_q <= lfsr[0];
      end
   end

   // Scoreboard results: saturating counters, mismatch pulse, sticky errors.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
         mismatch <= 1'b0;
         err      <= '0;
      end else begin
         mismatch <= pop_ok && !match;
         if (pop_ok) begin
            if (match) begin
               pass_cnt <= sat_inc(pass_cnt);
            end else begin
               fail_cnt <= sat_inc(fail_cnt);
            end
         end
         if (unexpected) begin
            err[ERR_UNEXPECTED] <= 1'b1;
         end
         if (overflow) begin
            err[ERR_OVERFLOW] <= 1'b1;
         end
         if (timeout_hit) begin
            err[ERR_TIMEOUT] <= 1'b1;
         end
      end
   end

   // Phase register and drain-timeout counter.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state   <= ST_RUN;
         tmo_cnt <= '0;
      end else begin
         state   <= state_next;
         tmo_cnt <= tmo_next;
      end
   end

   // Phase sequencing: run until told to stop, drain the queue, then hold.
   always_comb begin
      state_next  = state;
      tmo_next    = tmo_cnt;
      timeout_hit = 1'b0;
      case (state)
         ST_RUN: begin
            if (i_END) begin
               state_next = ST_DRAIN;
               tmo_next   = '0;
            end
         end
         ST_DRAIN: begin
            if (fifo_count == '0) begin
               state_next = ST_DONE;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_next  = ST_DONE;
            end else begin
               tmo_next = tmo_cnt + TW'(1);
            end
         end
         default: begin
            state_next = state;
         end
      endcase
   end

   assign o_res_READY = i_BP_EN ? ready_q : 1'b1;
   assign o_MISMATCH  = mismatch;
   assign o_PASS_CNT  = pass_cnt;
   assign o_FAIL_CNT  = fail_cnt;
   assign o_ERR       = err;
   assign o_DONE      = (state == ST_DONE);
   assign o_PASS      = o_DONE && (fail_cnt == '0) && (err == '0);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker. The bench plays the part of the
// ALU: it issues requests and returns results it computes itself.
module tb_alu_result_checker;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_arg0;
   logic [7:0]  req_arg1;
   logic [1:0]  req_oper;
   logic        res_valid;
   logic        res_ready;
   logic [10:0] res_y;
   logic        bp_en;
   logic        end_p;
   logic        mismatch;
   logic [15:0] pass_cnt;
   logic [15:0] fail_cnt;
   logic [2:0]  err;
   logic        done;
   logic        pass;

   int checks;
   int failures;
   int ready_low_cycles;

   alu_result_checker dut (
      .i_CLK      (clk),
      .i_RST      (rst),
      .i_req_VALID(req_valid),
      .i_req_READY(req_ready),
      .i_req_arg0 (req_arg0),
      .i_req_arg1 (req_arg1),
      .i_req_oper (req_oper),
      .i_res_VALID(res_valid),
      .o_res_READY(res_ready),
      .i_res_Y    (res_y),
      .i_BP_EN    (bp_en),
      .i_END      (end_p),
      .o_MISMATCH (mismatch),
      .o_PASS_CNT (pass_cnt),
      .o_FAIL_CNT (fail_cnt),
      .o_ERR      (err),
      .o_DONE     (done),
      .o_PASS     (pass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Independent ALU model in integer arithmetic, truncated to 11 bits.
   function automatic logic [10:0] alu_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      int r;
      case (op)
         2'b00:   r = int'(a) + int'(b);
         2'b01:   r = int'(a) - int'(b);
         2'b10:   r = int'(a & b);
         default: r = $countones(a);
      endcase
      return 11'(r & 32'h7FF);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 1'b0;
      req_ready = 1'b0;
      req_arg0  = '0;
      req_arg1  = '0;
      req_oper  = '0;
      res_valid = 1'b0;
      res_y     = '0;
      bp_en     = 1'b0;
      end_p     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
   endtask

   task automatic send_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      req_valid = 1'b1;
      req_ready = 1'b1;
      req_oper  = op;
      req_arg0  = a;
      req_arg1  = b;
      step();
      req_valid = 1'b0;
      req_ready = 1'b0;
   endtask

   task automatic send_res(input logic [10:0] y);
      int waited;
      waited    = 0;
      res_valid = 1'b1;
      res_y     = y;
      while (!res_ready && waited < 100) begin
         step();
         waited++;
         ready_low_cycles++;
      end
      if (!res_ready) begin
         checks++;
         failures++;
         $display("[TB] FAIL ready_wait: got ready=0 after %0d cycles expected ready=1", waited);
      end
      step();
      res_valid = 1'b0;
   endtask

   task automatic pulse_end_and_wait(input int limit, output int cycles);
      end_p = 1'b1;
      step();
      end_p  = 1'b0;
      cycles = 1;
      while (!done && cycles < limit) begin
         step();
         cycles++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (res_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %0b expected 1", res_ready); end
      checks++; if (mismatch !== 1'b0) begin failures++; $display("[TB] FAIL reset_mismatch: got %0b expected 0", mismatch); end
      checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_counts: got pass=%0d fail=%0d expected 0 0", pass_cnt, fail_cnt); end
      checks++; if (err !== 3'b000 || done !== 1'b0 || pass !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags: got err=%b done=%b pass=%b expected 000 0 0", err, done, pass); end
   endtask

   task automatic test_add();
      do_reset();
      send_req(2'b00, 8'd200, 8'd100);
      send_res(11'h12C);
      checks++; if (mismatch !== 1'b0) begin failures++; $display("[TB] FAIL add_mismatch: got %0b expected 0", mismatch); end
      checks++; if (pass_cnt !== 16'd1) begin failures++; $display("[TB] FAIL add_pass_cnt: got %0d expected 1", pass_cnt); end
   endtask

   task automatic test_ops();
      do_reset();
      send_req(2'b01, 8'd5, 8'd10);
      send_res(11'h7FB);
      send_req(2'b10, 8'hF0, 8'h3C);
      send_res(11'h030);
      send_req(2'b11, 8'hFF, 8'h00);
      send_res(11'h008);
      checks++; if (pass_cnt !== 16'd3) begin failures++; $display("[TB] FAIL ops_pass_cnt: got %0d expected 3", pass_cnt); end
      checks++; if (fail_cnt !== 16'd0 || err !== 3'b000) begin failures++; $display("[TB] FAIL ops_clean: got fail=%0d err=%b expected 0 000", fail_cnt, err); end
   endtask

   task automatic test_mismatch();
      int cycles;
      do_reset();
      send_req(2'b00, 8'd200, 8'd100);
      send_res(11'h000);
      checks++; if (mismatch !== 1'b1) begin failures++; $display("[TB] FAIL mm_pulse: got %0b expected 1", mismatch); end
      step();
      checks++; if (mismatch !== 1'b0) begin failures++; $display("[TB] FAIL mm_pulse_end: got %0b expected 0", mismatch); end
      checks++; if (fail_cnt !== 16'd1 || pass_cnt !== 16'd0) begin failures++; $display("[TB] FAIL mm_counts: got fail=%0d pass=%0d expected 1 0", fail_cnt, pass_cnt); end
      pulse_end_and_wait(10, cycles);
      checks++; if (done !== 1'b1 || pass !== 1'b0) begin failures++; $display("[TB] FAIL mm_verdict: got done=%b pass=%b expected 1 0", done, pass); end
      send_res(11'h012);
      checks++; if (err !== 3'b001) begin failures++; $display("[TB] FAIL mm_late_result: got err=%b expected 001", err); end
   endtask

   task automatic test_unexpected();
      do_reset();
      send_res(11'h055);
      checks++; if (err !== 3'b001) begin failures++; $display("[TB] FAIL unexp_err: got %b expected 001", err); end
      repeat (3) step();
      checks++; if (err !== 3'b001) begin failures++; $display("[TB] FAIL unexp_sticky: got %b expected 001", err); end
      checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin failures++; $display("[TB] FAIL unexp_counts: got pass=%0d fail=%0d expected 0 0", pass_cnt, fail_cnt); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         send_req(2'b00, 8'(i), 8'(i));
      end
      checks++; if (err !== 3'b010) begin failures++; $display("[TB] FAIL ovf_err: got %b expected 010", err); end
      for (int i = 1; i <= 8; i++) begin
         send_res(11'(2 * i));
      end
      checks++; if (pass_cnt !== 16'd8 || fail_cnt !== 16'd0) begin failures++; $display("[TB] FAIL ovf_drain: got pass=%0d fail=%0d expected 8 0", pass_cnt, fail_cnt); end
      send_res(11'd18);
      checks++; if (err !== 3'b011) begin failures++; $display("[TB] FAIL ovf_dropped: got err=%b expected 011", err); end
   endtask

   task automatic test_back_to_back();
      int cycles;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
      do_reset();
      bp_en            = 1'b1;
      ready_low_cycles = 0;
      for (int i = 0; i < 80; i++) begin
         op = 2'(i % 4);
         a  = 8'((i * 37 + 5) & 255);
         b  = 8'((i * 91 + 3) & 255);
         send_req(op, a, b);
         send_res(alu_model(op, a, b));
      end
      pulse_end_and_wait(10, cycles);
      checks++; if (ready_low_cycles == 0) begin failures++; $display("[TB] FAIL bp_ready_low: got %0d low cycles expected >0", ready_low_cycles); end
      checks++; if (pass_cnt !== 16'd80 || fail_cnt !== 16'd0) begin failures++; $display("[TB] FAIL bp_counts: got pass=%0d fail=%0d expected 80 0", pass_cnt, fail_cnt); end
      checks++; if (done !== 1'b1 || pass !== 1'b1 || err !== 3'b000) begin failures++; $display("[TB] FAIL bp_verdict: got done=%b pass=%b err=%b expected 1 1 000", done, pass, err); end
   endtask

   task automatic test_timeout();
      int cycles;
      do_reset();
      send_req(2'b00, 8'd1, 8'd1);
      send_req(2'b00, 8'd2, 8'd2);
      pulse_end_and_wait(200, cycles);
      // one cycle to enter DRAIN, then 64 drain cycles
      checks++; if (cycles !== 65) begin failures++; $display("[TB] FAIL tmo_cycles: got %0d expected 65", cycles); end
      checks++; if (err !== 3'b100 || done !== 1'b1 || pass !== 1'b0) begin failures++; $display("[TB] FAIL tmo_flags: got err=%b done=%b pass=%b expected 100 1 0", err, done, pass); end
   endtask

   task automatic test_reset_mid();
      int waited;
      int cycles;
      do_reset();
      send_req(2'b00, 8'd1, 8'd2);
      send_res(11'd3);
      bp_en = 1'b1;
      send_req(2'b10, 8'hAA, 8'h0F);
      send_req(2'b10, 8'hAA, 8'hF0);
      send_req(2'b11, 8'h81, 8'h00);
      waited = 0;
      while (res_ready && waited < 100) begin
         step();
         waited++;
      end
      checks++; if (res_ready !== 1'b0) begin failures++; $display("[TB] FAIL rmid_ready_low: got %0b expected 0", res_ready); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (res_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_async_ready: got %0b expected 1", res_ready); end
      checks++; if (pass_cnt !== 16'd0 || err !== 3'b000) begin failures++; $display("[TB] FAIL rmid_cleared: got pass=%0d err=%b expected 0 000", pass_cnt, err); end
      step();
      rst   = 1'b0;
      bp_en = 1'b0;
      step();
      pulse_end_and_wait(10, cycles);
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin failures++; $display("[TB] FAIL rmid_fifo_empty: got done=%b pass=%b expected 1 1", done, pass); end
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      ready_low_cycles = 0;
      test_reset();
      test_add();
      test_ops();
      test_mismatch();
      test_unexpected();
      test_overflow();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Self-checking sink for the ALU output stream. It is the consumer end of the ALU valid/ready result interface, so it drives the ALU's i_READY instead of a tied-high constant. It snoops accepted ALU requests, computes the reference result into an expected-value FIFO, and compares each accepted ALU result against it. It also applies configurable pseudo-random backpressure and reports pass/fail counts plus an end-of-test verdict.

Parameters:
DATA_WIDTH, 8, ALU operand width
OUT_WIDTH, DATA_WIDTH+3, ALU result width
DEPTH, 8, expected-FIFO entries (power of 2)
SEED, 16'hACE1, nonzero seed for the 16-bit backpressure LFSR
TIMEOUT, 64, drain-phase cycle limit

Ports:
i_CLK  in  1  clock
i_RST  in  1  asynchronous, active-high reset
i_req_VALID  in  1  ALU request valid (snooped)
i_req_READY  in  1  ALU request ready (snooped); request fires when both are 1
i_req_arg0  in  DATA_WIDTH  operand 0
i_req_arg1  in  DATA_WIDTH  operand 1
i_req_oper  in  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 popcount(arg0)
i_res_VALID  in  1  ALU o_VALID
o_res_READY  out  1  drives ALU i_READY
i_res_Y  in  OUT_WIDTH  ALU o_Y
i_BP_EN  in  1  1 = LFSR backpressure, 0 = ready always high
i_END  in  1  one-cycle pulse: stimulus finished, enter drain
o_MISMATCH  out  1  one-cycle pulse on a compare failure
o_PASS_CNT  out  16  matched results, saturating
o_FAIL_CNT  out  16  mismatched results, saturating
o_ERR  out  3  sticky flags: [0] unexpected result, [1] FIFO overflow, [2] drain timeout
o_DONE  out  1  verdict valid
o_PASS  out  1  1 when o_DONE, FAIL_CNT==0 and ERR==0

Behaviour:
- Reset, asynchronous active-high: all outputs 0 except o_res_READY=1. FIFO empty, LFSR=SEED, state=RUN. Reset mid-test discards all FIFO contents and counters.
- Expected value, computed combinationally at request fire and pushed the same edge:
  - ADD: zero-extended arg0+arg1.
  - SUB: arg0-arg1 as two's complement, sign-extended to OUT_WIDTH.
  - AND: zero-extended arg0&arg1.
  - POPCNT: number of ones in arg0, zero-extended.
- Result acceptance:
  - A result is accepted when i_res_VALID && o_res_READY. On acceptance, the FIFO head is popped and compared.
  - Match: PASS_CNT+1. Mismatch: FAIL_CNT+1 and o_MISMATCH=1 the next cycle.
- Backpressure: when i_BP_EN=1, o_res_READY is registered LFSR bit 0. The LFSR is Fibonacci x^16+x^14+x^13+x^11+1 and advances every cycle. When i_BP_EN=0, o_res_READY=1 and the LFSR keeps running.
- Simultaneous push and pop: the FIFO count is unchanged. There is no bypass, so a pop when the FIFO is empty sets ERR[0] even if a push happens that cycle (ALU latency ≥1 cycle makes this a real error). No counter update occurs on that pop.
- Push when full with no pop: the entry is dropped and ERR[1] is set. Push when full with a pop in the same cycle is legal.
- Counters saturate at 16'hFFFF.
- FSM:
  - RUN: accept and compare results. i_END moves to DRAIN and clears the timeout counter.
  - DRAIN: keep accepting results. FIFO empty moves to DONE. The timeout counter reaching TIMEOUT sets ERR[2] and moves to DONE.
  - DONE: o_DONE=1 and o_PASS valid. Late results still compare and set ERR[0] if unexpected, and o_PASS updates accordingly. Only reset leaves DONE.
- i_END while in DRAIN or DONE is ignored.

Decomposition:
- Shared header alu_defs.vh: opcode localparams OP_ADD/OP_SUB/OP_AND/OP_POPCNT, ERR bit indices, FSM state encodings. The ALU and the checker both include it.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count). It is reusable by other stream blocks.

Test Plan:
- ADD 200+100, BP off → expected 11'h12C; ALU returns 11'h12C → PASS_CNT=1, o_MISMATCH stays 0.
- SUB 5-10 → expected 11'h7FB; AND 8'hF0&8'h3C → 11'h030; POPCNT 8'hFF → 11'h008; all matched → PASS_CNT=3.
- Inject i_res_Y=11'h000 against expected 11'h12C → o_MISMATCH pulse 1 cycle, FAIL_CNT=1; after i_END and drain → o_DONE=1, o_PASS=0.
- Result valid with FIFO empty → ERR[0] set and sticky. Push 9 requests (DEPTH=8) with i_res_VALID=0 → ERR[1] set and FIFO count=8.
- BP on, 80 random requests through the ALU, then i_END → o_res_READY low on some cycles, PASS_CNT=80, o_PASS=1.
- i_END with 2 entries pending and no results → DONE after 64 cycles, ERR[2]=1. Assert i_RST in RUN with 3 entries pending → FIFO empty, counters 0, o_res_READY=1 immediately (asynchronous).
